// File: rtl/bp_be_stride_prefetch_scheduler_pkg.sv
// Shared types for the stride prefetch scheduler: stream entry layout and credit sizing.
`default_nettype none

`define BP_BE_DECLARE_STRIDE_STREAM_S(vaddr_width_mp, stride_width_mp, page_offset_width_mp, credit_width_mp) \
  typedef struct packed { \
    logic                                        v; \
    logic [vaddr_width_mp-1:0]                   pc; \
    logic [vaddr_width_mp-1:0]                   next_addr; \
    logic [stride_width_mp-1:0]                  stride; \
    logic [vaddr_width_mp-page_offset_width_mp-1:0] tag; \
    logic [credit_width_mp-1:0]                  credits; \
  } bp_be_stride_stream_s

package bp_be_stride_prefetch_scheduler_pkg;

  localparam int unsigned bp_be_default_degree_gp = 4;

  // Credits count down from degree to 0 inclusive.
  function automatic int unsigned bp_be_credit_width(input int unsigned degree);
    return $clog2(degree + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_arb_round_robin.sv
// Round-robin grant: priority starts at the index after the last accepted grant.
`default_nettype none

module bsg_arb_round_robin #(
  parameter int width_p = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       clear_i,
  input  logic [width_p-1:0]         reqs_i,
  output logic [$clog2(width_p)-1:0] grant_o,
  output logic                       v_o,
  input  logic                       yumi_i
);

  localparam int lg_width_lp = $clog2(width_p);

  logic [lg_width_lp-1:0] prio_q, prio_d;
  logic [lg_width_lp-1:0] idx;

  // Scan from highest offset down so the nearest request to prio_q wins.
  always_comb begin
    v_o     = 1'b0;
    grant_o = '0;
    idx     = '0;
    for (int k = width_p - 1; k >= 0; k--) begin
      idx = prio_q + lg_width_lp'(k);
      if (reqs_i[idx]) begin
        v_o     = 1'b1;
        grant_o = idx;
      end
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (clear_i)
      prio_d = '0;
    else if (yumi_i && v_o)
      prio_d = grant_o + lg_width_lp'(1);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      prio_q <= '0;
    else
      prio_q <= prio_d;
  end

endmodule

`default_nettype wire

// File: rtl/bp_be_stride_prefetch_scheduler.sv
// Tracks confirmed striding loads by PC and issues a budget of prefetches per
// confirmation, one request per accepted handshake, never crossing a page.
`default_nettype none

module bp_be_stride_prefetch_scheduler
  import bp_be_stride_prefetch_scheduler_pkg::*;
#(
  parameter int vaddr_width_p       = 39,
  parameter int stride_width_p      = 8,
  parameter int streams_p           = 4,
  parameter int degree_p            = bp_be_default_degree_gp,
  parameter int page_offset_width_p = 12
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      confirm_v_i,
  input  logic [vaddr_width_p-1:0]  confirm_pc_i,
  input  logic [vaddr_width_p-1:0]  confirm_addr_i,
  input  logic [stride_width_p-1:0] confirm_stride_i,
  input  logic                      flush_i,
  output logic                      pf_v_o,
  output logic [vaddr_width_p-1:0]  pf_addr_o,
  input  logic                      pf_ready_i,
  output logic [streams_p-1:0]      active_o
);

  localparam int credit_width_lp = bp_be_credit_width(degree_p);
  localparam int idx_width_lp    = $clog2(streams_p);

  `BP_BE_DECLARE_STRIDE_STREAM_S(vaddr_width_p, stride_width_p, page_offset_width_p, credit_width_lp);

  function automatic logic [vaddr_width_p-1:0] sext(input logic [stride_width_p-1:0] s);
    return {{(vaddr_width_p - stride_width_p){s[stride_width_p-1]}}, s};
  endfunction

  bp_be_stride_stream_s [streams_p-1:0] streams_q, streams_d;
  logic [idx_width_lp-1:0]  repl_q, repl_d;
  logic                     pf_v_q, pf_v_d;
  logic [vaddr_width_p-1:0] pf_addr_q, pf_addr_d;

  logic [streams_p-1:0]     eligible;
  logic [idx_width_lp-1:0]  grant_idx;
  logic                     grant_v;
  logic                     load_en;
  logic                     issue_en;

  logic                     hit_v, free_v, confirm_en;
  logic [idx_width_lp-1:0]  hit_idx, free_idx, confirm_idx;
  logic [vaddr_width_p-1:0] confirm_next;

  for (genvar i = 0; i < streams_p; i++) begin : g_stream
    assign active_o[i] = streams_q[i].v;
    assign eligible[i] = streams_q[i].v
                       && (streams_q[i].credits != '0)
                       && (streams_q[i].next_addr[vaddr_width_p-1:page_offset_width_p] == streams_q[i].tag);
  end

  // Output register reloads when empty or being consumed this cycle.
  assign load_en  = !pf_v_q || pf_ready_i;
  assign issue_en = load_en && grant_v && !flush_i;

  bsg_arb_round_robin #(
    .width_p (streams_p)
  ) arb (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (flush_i),
    .reqs_i    (eligible),
    .grant_o   (grant_idx),
    .v_o       (grant_v),
    .yumi_i    (issue_en)
  );

  // PC match; lowest-index invalid slot is the allocation choice on a miss.
  always_comb begin
    hit_v    = 1'b0;
    hit_idx  = '0;
    free_v   = 1'b0;
    free_idx = '0;
    for (int i = streams_p - 1; i >= 0; i--) begin
      if (streams_q[i].v && (streams_q[i].pc == confirm_pc_i)) begin
        hit_v   = 1'b1;
        hit_idx = idx_width_lp'(i);
      end
      if (!streams_q[i].v) begin
        free_v   = 1'b1;
        free_idx = idx_width_lp'(i);
      end
    end
  end

  assign confirm_en   = confirm_v_i && (confirm_stride_i != '0);
  assign confirm_idx  = hit_v ? hit_idx : (free_v ? free_idx : repl_q);
  assign confirm_next = confirm_addr_i + sext(confirm_stride_i);

  // Issue is applied first so that a same-entry confirm overwrites its update.
  always_comb begin
    streams_d = streams_q;
    repl_d    = repl_q;
    pf_v_d    = pf_v_q;
    pf_addr_d = pf_addr_q;

    if (load_en) begin
      pf_v_d = grant_v;
      if (grant_v) begin
        pf_addr_d = streams_q[grant_idx].next_addr;
        streams_d[grant_idx].next_addr = streams_q[grant_idx].next_addr
                                       + sext(streams_q[grant_idx].stride);
        streams_d[grant_idx].credits   = streams_q[grant_idx].credits
                                       - credit_width_lp'(1);
      end
    end

    if (confirm_en) begin
      if (!hit_v && !free_v)
        repl_d = repl_q + idx_width_lp'(1);
      streams_d[confirm_idx].v         = 1'b1;
      streams_d[confirm_idx].pc        = confirm_pc_i;
      streams_d[confirm_idx].next_addr = confirm_next;
      streams_d[confirm_idx].stride    = confirm_stride_i;
      streams_d[confirm_idx].tag       = confirm_next[vaddr_width_p-1:page_offset_width_p];
      streams_d[confirm_idx].credits   = credit_width_lp'(degree_p);
    end

    if (flush_i) begin
      for (int i = 0; i < streams_p; i++) begin
        streams_d[i].v       = 1'b0;
        streams_d[i].credits = '0;
      end
      repl_d = '0;
      pf_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      streams_q <= '0;
      repl_q    <= '0;
      pf_v_q    <= 1'b0;
      pf_addr_q <= '0;
    end else begin
      streams_q <= streams_d;
      repl_q    <= repl_d;
      pf_v_q    <= pf_v_d;
      pf_addr_q <= pf_addr_d;
    end
  end

  assign pf_v_o    = pf_v_q;
  assign pf_addr_o = pf_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_bp_be_stride_prefetch_scheduler.sv
// Directed and randomized checks of the stride prefetch scheduler against a stream-table model.
`default_nettype none

module tb_bp_be_stride_prefetch_scheduler;

  localparam int VA  = 39;
  localparam int SW  = 8;
  localparam int NS  = 4;
  localparam int DEG = 4;
  localparam int PO  = 12;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          conf_v;
  logic [VA-1:0] conf_pc;
  logic [VA-1:0] conf_addr;
  logic [SW-1:0] conf_stride;
  logic          flush;
  logic          pf_v;
  logic [VA-1:0] pf_addr;
  logic          ready;
  logic [NS-1:0] active;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  bp_be_stride_prefetch_scheduler #(
    .vaddr_width_p       (VA),
    .stride_width_p      (SW),
    .streams_p           (NS),
    .degree_p            (DEG),
    .page_offset_width_p (PO)
  ) dut (
    .clk_i            (clk),
    .reset_n_i        (reset_n),
    .confirm_v_i      (conf_v),
    .confirm_pc_i     (conf_pc),
    .confirm_addr_i   (conf_addr),
    .confirm_stride_i (conf_stride),
    .flush_i          (flush),
    .pf_v_o           (pf_v),
    .pf_addr_o        (pf_addr),
    .pf_ready_i       (ready),
    .active_o         (active)
  );

  // Reference: a table of streams plus the output slot, advanced once per clock edge.
  bit            m_v     [NS];
  logic [VA-1:0] m_pc    [NS];
  logic [VA-1:0] m_next  [NS];
  logic [SW-1:0] m_stride[NS];
  int            m_page  [NS];
  int            m_cred  [NS];
  int            m_repl;
  int            m_rr;
  bit            m_pfv;
  logic [VA-1:0] m_pfaddr;

  function automatic logic [VA-1:0] ext(input logic [SW-1:0] s);
    logic signed [VA-1:0] r;
    r = $signed(s);
    return r;
  endfunction

  function automatic int page_of(input logic [VA-1:0] a);
    return int'(a >> PO);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NS; i++) begin
      m_v[i]    = 1'b0;
      m_cred[i] = 0;
    end
    m_repl = 0;
    m_rr   = 0;
    m_pfv  = 1'b0;
  endtask

  task automatic model_reset();
    model_clear();
    for (int i = 0; i < NS; i++) begin
      m_pc[i] = '0; m_next[i] = '0; m_stride[i] = '0; m_page[i] = 0;
    end
    m_pfaddr = '0;
  endtask

  task automatic model_step();
    int  slot;
    bit  evict;
    bit  found;
    int  w;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (flush) begin
      model_clear();
      return;
    end
    slot  = -1;
    evict = 1'b0;
    for (int i = 0; i < NS; i++)
      if (m_v[i] && m_pc[i] == conf_pc) slot = i;
    if (slot < 0)
      for (int i = NS - 1; i >= 0; i--)
        if (!m_v[i]) slot = i;
    if (slot < 0) begin
      slot  = m_repl;
      evict = 1'b1;
    end
    if (!m_pfv || ready) begin
      found = 1'b0;
      w     = 0;
      for (int k = 0; k < NS; k++) begin
        int c;
        c = (m_rr + k) % NS;
        if (!found && m_v[c] && m_cred[c] != 0 && page_of(m_next[c]) == m_page[c]) begin
          found = 1'b1;
          w     = c;
        end
      end
      m_pfv = found;
      if (found) begin
        m_pfaddr  = m_next[w];
        m_next[w] = m_next[w] + ext(m_stride[w]);
        m_cred[w] = m_cred[w] - 1;
        m_rr      = (w + 1) % NS;
      end
    end
    if (conf_v && conf_stride != 0) begin
      if (evict) m_repl = (m_repl + 1) % NS;
      m_v[slot]      = 1'b1;
      m_pc[slot]     = conf_pc;
      m_next[slot]   = conf_addr + ext(conf_stride);
      m_stride[slot] = conf_stride;
      m_page[slot]   = page_of(m_next[slot]);
      m_cred[slot]   = DEG;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    logic [NS-1:0] mask;
    for (int i = 0; i < NS; i++) mask[i] = m_v[i];
    chk("model_pf_v", 64'(pf_v), 64'(m_pfv));
    chk("model_active", 64'(active), 64'(mask));
    if (m_pfv) chk("model_pf_addr", 64'(pf_addr), 64'(m_pfaddr));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk_model();
  endtask

  task automatic confirm_once(input logic [VA-1:0] pc, input logic [VA-1:0] addr,
                              input logic [SW-1:0] stride);
    conf_v = 1'b1; conf_pc = pc; conf_addr = addr; conf_stride = stride;
    tick();
    conf_v = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; conf_v = 1'b0; conf_pc = '0; conf_addr = '0; conf_stride = '0;
    flush = 1'b0; ready = 1'b1;
    model_reset();
    repeat (3) tick();
    chk("reset_pf_v", 64'(pf_v), 64'd0);
    chk("reset_pf_addr", 64'(pf_addr), 64'd0);
    chk("reset_active", 64'(active), 64'd0);
    reset_n = 1'b1;
    tick();

    // Single stream, ready held high.
    confirm_once('h80000100, 'h1000, 8'd8);
    chk("single_t1_idle", 64'(pf_v), 64'd0);
    for (int j = 1; j <= 5; j++) begin
      tick();
      if (j <= 4) chk("single_addr", 64'(pf_addr), 64'h1000 + 64'(8 * j));
      else        chk("single_done", 64'(pf_v), 64'd0);
    end

    // Backpressure holds the first request.
    do_flush();
    ready = 1'b0;
    confirm_once('h80000100, 'h1000, 8'd8);
    for (int j = 0; j < 6; j++) begin
      tick();
      chk("bp_hold", 64'(pf_addr), 64'h1008);
    end
    ready = 1'b1;
    for (int j = 2; j <= 4; j++) begin
      tick();
      chk("bp_resume", 64'(pf_addr), 64'h1000 + 64'(8 * j));
    end
    tick();
    chk("bp_done", 64'(pf_v), 64'd0);

    // Page crossing is suppressed.
    do_flush();
    confirm_once('h80000200, 'h1FF0, 8'd8);
    tick();
    chk("page_first", 64'(pf_addr), 64'h1FF8);
    tick();
    chk("page_stop", 64'(pf_v), 64'd0);
    tick();

    // Negative stride with a re-arm while issuing.
    do_flush();
    confirm_once('h80000300, 'h3000, 8'hF0);
    tick();
    chk("neg_first", 64'(pf_addr), 64'h2FF0);
    confirm_once('h80000300, 'h2FE0, 8'hF0);
    chk("neg_second", 64'(pf_addr), 64'h2FE0);
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("neg_rearm", 64'(pf_addr), 64'h2FD0 - 64'(16 * j));
    end
    tick();
    chk("neg_done", 64'(pf_v), 64'd0);

    // Five PCs into four slots; the fifth replaces slot 0.
    do_flush();
    ready = 1'b0;
    for (int j = 0; j < 5; j++)
      confirm_once(VA'('h80001000 + 64'(j * 'h40)), VA'('h10000 + 64'(j * 'h1000)), 8'd4);
    chk("repl_active", 64'(active), 64'hF);
    ready = 1'b1;
    repeat (18) tick();

    // Two armed streams alternate grants.
    do_flush();
    confirm_once('h100, 'h5000, 8'd4);
    confirm_once('h200, 'h6000, 8'd4);
    chk("rr_a0", 64'(pf_addr), 64'h5004);
    tick(); chk("rr_b0", 64'(pf_addr), 64'h6004);
    tick(); chk("rr_a1", 64'(pf_addr), 64'h5008);
    tick(); chk("rr_b1", 64'(pf_addr), 64'h6008);
    repeat (6) tick();

    // Randomized traffic.
    for (int j = 0; j < 600; j++) begin
      conf_v      = ($urandom_range(0, 99) < 30);
      conf_pc     = VA'('h80000000 + 64'($urandom_range(0, 5) * 'h40));
      conf_addr   = VA'({$urandom, $urandom});
      conf_stride = SW'($urandom_range(0, 255));
      ready       = ($urandom_range(0, 99) < 60);
      flush       = ($urandom_range(0, 99) < 2);
      tick();
    end
    conf_v = 1'b0; flush = 1'b0; ready = 1'b1;

    // Flush drops a pending request.
    do_flush();
    ready = 1'b0;
    confirm_once('h80000400, 'h7000, 8'd8);
    tick();
    chk("flush_pending", 64'(pf_v), 64'd1);
    do_flush();
    chk("flush_pf_v", 64'(pf_v), 64'd0);
    chk("flush_active", 64'(active), 64'd0);
    ready = 1'b1;
    repeat (3) tick();

    // Asynchronous reset mid-stream.
    confirm_once('h80000500, 'h8000, 8'd8);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset_pf_v", 64'(pf_v), 64'd0);
    chk("areset_addr", 64'(pf_addr), 64'd0);
    chk("areset_active", 64'(active), 64'd0);
    model_reset();
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
